// File: rtl/slave_rd_master.sv
// Read master for the slave RAM/header port: fetches a 16-bit header and PAYLOAD_LEN payload bytes per message.
// Optional header sequence check is compiled in with `define SLAVE_RD_SEQ_CHECK_EN.
module slave_rd_master #(
  parameter int PAYLOAD_LEN = 16,
  parameter int RD_LAT      = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ram_rd_rq,
  output logic [15:0] o_rd_addr,
  input  logic [7:0]  i_rd_data,
  output logic [15:0] o_msg_hdr,
  output logic        o_hdr_valid,
  output logic [7:0]  o_out_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_out_last,
  output logic        o_seq_err,
  output logic [1:0]  o_state
);
  // Output stream: a byte transfers on every clock where o_out_valid && i_out_ready;
  // o_out_valid never drops without a transfer, and o_out_data/o_out_last are stable while valid.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] K_HI  = 2'd0;
  localparam logic [1:0] K_LO  = 2'd1;
  localparam logic [1:0] K_PAY = 2'd2;

  typedef enum logic [1:0] {IDLE, HDR, PAY, DRAIN} state_t;

  state_t         r_state;
  logic           r_busy, r_done, r_rd_rq, r_hdr_valid;
  logic [15:0]    r_rd_addr, r_msg_hdr;
  logic [7:0]     r_idx;
  logic [1:0]     r_kind;
  logic           r_last;
  logic           r_tv [RD_LAT];
  logic [1:0]     r_tk [RD_LAT];
  logic           r_tl [RD_LAT];
  logic [8:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_out_valid, r_out_last;
  logic [7:0]     r_out_data;

  logic           w_em_v, w_em_l, w_push, w_pop, w_full, w_early, w_credit, w_accept, w_lo_cap;
  logic [1:0]     w_em_k;
  logic [2:0]     w_pipe_pay;
  logic [15:0]    w_pending, w_hdr_full;
  logic [CW-1:0]  w_count_nxt;
  logic [AW-1:0]  w_rd_nxt;
  logic [8:0]     w_head;

  assign w_em_v   = r_tv[RD_LAT-1];
  assign w_em_k   = r_tk[RD_LAT-1];
  assign w_em_l   = r_tl[RD_LAT-1];
  assign w_push   = w_em_v && (w_em_k == K_PAY);
  assign w_lo_cap = w_em_v && (w_em_k == K_LO);
  assign w_pop    = r_out_valid && i_out_ready;
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_accept = (r_state == IDLE) && i_start;
  assign w_hdr_full = {r_msg_hdr[15:8], i_rd_data};

  always_comb begin
    w_pipe_pay = '0;
    w_early    = 1'b0;
    for (int i = 0; i < RD_LAT; i++)
      if (r_tv[i] && (r_tk[i] == K_PAY)) w_pipe_pay = w_pipe_pay + 3'd1;
    for (int i = 0; i < RD_LAT - 1; i++)
      w_early = w_early | r_tv[i];
  end

  // Credit counts every payload byte already owed to the FIFO, including the read on the bus now.
  assign w_pending   = 16'(r_count) + 16'(w_pipe_pay) + 16'(r_rd_rq && (r_kind == K_PAY));
  assign w_credit    = (w_pending < 16'(FIFO_DEPTH));
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_rd_nxt    = r_rd_ptr + AW'(w_pop);
  assign w_head      = (w_push && (r_wr_ptr == w_rd_nxt)) ? {w_em_l, i_rd_data} : r_mem[w_rd_nxt];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_rq     <= 1'b0;
      r_rd_addr   <= '0;
      r_idx       <= '0;
      r_kind      <= K_HI;
      r_last      <= 1'b0;
      r_msg_hdr   <= '0;
      r_hdr_valid <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_tv[i] <= 1'b0;
        r_tk[i] <= K_HI;
        r_tl[i] <= 1'b0;
      end
    end else begin
      r_rd_rq     <= 1'b0;
      r_done      <= 1'b0;
      r_hdr_valid <= 1'b0;
      case (r_state)
        IDLE: if (i_start) begin
          r_busy    <= 1'b1;
          r_rd_rq   <= 1'b1;
          r_rd_addr <= 16'd0;
          r_kind    <= K_HI;
          r_last    <= 1'b0;
          r_state   <= HDR;
        end
        HDR: begin
          r_rd_rq   <= 1'b1;
          r_rd_addr <= 16'd1;
          r_kind    <= K_LO;
          r_idx     <= '0;
          r_state   <= PAY;
        end
        PAY: if (w_credit) begin
          r_rd_rq   <= 1'b1;
          r_rd_addr <= 16'd2 + 16'(r_idx);
          r_kind    <= K_PAY;
          r_last    <= (r_idx == 8'(PAYLOAD_LEN - 1));
          r_idx     <= r_idx + 8'd1;
          if (r_idx == 8'(PAYLOAD_LEN - 1)) r_state <= DRAIN;
        end
        DRAIN: if (!r_rd_rq && !w_early) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      r_tv[0] <= r_rd_rq;
      r_tk[0] <= r_kind;
      r_tl[0] <= r_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tv[i] <= r_tv[i-1];
        r_tk[i] <= r_tk[i-1];
        r_tl[i] <= r_tl[i-1];
      end

      if (w_em_v && (w_em_k == K_HI)) r_msg_hdr[15:8] <= i_rd_data;
      if (w_lo_cap) begin
        r_msg_hdr[7:0] <= i_rd_data;
        r_hdr_valid    <= 1'b1;
      end

      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr    <= w_rd_nxt;
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != '0);
      r_out_last  <= w_head[8];
      r_out_data  <= w_head[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_em_l, i_rd_data};
  end

  assert property (@(posedge clk) disable iff (!rst_l) !(w_push && w_full));

`ifdef SLAVE_RD_SEQ_CHECK_EN
  logic [15:0] r_prev_hdr;
  logic        r_have_prev, r_seq_err;

  // The first header after reset only seeds the reference value.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_prev_hdr  <= '0;
      r_have_prev <= 1'b0;
      r_seq_err   <= 1'b0;
    end else if (w_accept) begin
      r_seq_err <= 1'b0;
    end else if (w_lo_cap) begin
      if (r_have_prev && (w_hdr_full != r_prev_hdr + 16'd1)) r_seq_err <= 1'b1;
      r_prev_hdr  <= w_hdr_full;
      r_have_prev <= 1'b1;
    end
  end
  assign o_seq_err = r_seq_err;
`else
  assign o_seq_err = 1'b0;
`endif

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_ram_rd_rq = r_rd_rq;
  assign o_rd_addr   = r_rd_addr;
  assign o_msg_hdr   = r_msg_hdr;
  assign o_hdr_valid = r_hdr_valid;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_state     = r_state;
endmodule

// File: tb/tb_slave_rd_master.sv
// Bench for slave_rd_master: slave latency model, address/header monitors and a payload scoreboard.
// Builds with or without SLAVE_RD_SEQ_CHECK_EN; seq_err expectations follow the macro.
module tb_slave_rd_master;
  localparam int P_LEN   = 16;
  localparam int P_LAT   = 4;
  localparam int P_DEPTH = 8;
`ifdef SLAVE_RD_SEQ_CHECK_EN
  localparam logic SEQ_EN = 1'b1;
`else
  localparam logic SEQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic        busy, done, ram_rd_rq, hdr_valid, out_valid, out_last, seq_err;
  logic [15:0] rd_addr, msg_hdr;
  logic [7:0]  rd_data, out_data;
  logic [1:0]  state;

  slave_rd_master #(.PAYLOAD_LEN(P_LEN), .RD_LAT(P_LAT), .FIFO_DEPTH(P_DEPTH)) u_dut (
    .clk(clk), .rst_l(rst_l), .i_start(start), .o_busy(busy), .o_done(done),
    .o_ram_rd_rq(ram_rd_rq), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_msg_hdr(msg_hdr), .o_hdr_valid(hdr_valid), .o_out_data(out_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_last(out_last),
    .o_seq_err(seq_err), .o_state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave: address sampled at the clock edge, data valid P_LAT cycles after the issue cycle.
  logic [15:0] cur_hdr = 16'h0;
  logic [7:0]  cur_base = 8'h0;
  logic [7:0]  s_d [P_LAT];

  function automatic logic [7:0] slave_byte(input logic [15:0] a);
    if (a == 16'd0) return cur_hdr[15:8];
    if (a == 16'd1) return cur_hdr[7:0];
    return cur_base + a[7:0] - 8'd2;
  endfunction

  always @(posedge clk) begin
    s_d[0] <= ram_rd_rq ? slave_byte(rd_addr) : 8'hEE;
    for (int i = 1; i < P_LAT; i++) s_d[i] <= s_d[i-1];
  end
  assign rd_data = s_d[P_LAT-1];

  logic [8:0]  exp_q[$];
  logic [8:0]  mon_e;
  logic [15:0] exp_addr = 16'd0;
  int cyc = 0, iss_cnt = 0, hdr_cnt = 0, done_cnt = 0, ovalid_cnt = 0;
  int first_iss_cyc = 0, last_iss_cyc = 0, done_cyc = 0, start_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (start && !busy && rst_l) start_cyc = cyc;
    if (ram_rd_rq) begin
      chk("rd_addr", 32'(rd_addr), 32'(exp_addr));
      if (exp_addr == 16'd0) first_iss_cyc = cyc;
      last_iss_cyc = cyc;
      exp_addr++;
      iss_cnt++;
    end
    if (hdr_valid) begin
      chk("msg_hdr", 32'(msg_hdr), 32'(cur_hdr));
      hdr_cnt++;
    end
    if (done) begin
      chk("busy_at_done", 32'(busy), 32'd0);
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_valid) ovalid_cnt++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_byte", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("payload", 32'({out_last, out_data}), 32'(mon_e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_msg(input logic [15:0] hdr, input logic [7:0] base);
    logic [8:0] ent;
    cur_hdr  = hdr;
    cur_base = base;
    exp_addr = 16'd0;
    for (int i = 0; i < P_LEN; i++) begin
      ent = {1'(i == P_LEN - 1), 8'(base + 8'(i))};
      exp_q.push_back(ent);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick(1);
      n++;
    end
    if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_done"}, 32'(done), 32'd0);
    chk({pfx, "_rq"}, 32'(ram_rd_rq), 32'd0);
    chk({pfx, "_addr"}, 32'(rd_addr), 32'd0);
    chk({pfx, "_hdr"}, 32'(msg_hdr), 32'd0);
    chk({pfx, "_hdr_valid"}, 32'(hdr_valid), 32'd0);
    chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({pfx, "_out_last"}, 32'(out_last), 32'd0);
    chk({pfx, "_seq_err"}, 32'(seq_err), 32'd0);
    chk({pfx, "_state"}, 32'(state), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, h0, d0, v0, n;
    tick(3);
    chk_reset_vals("reset");
    rst_l = 1'b1;
    tick(2);

    // Straight-through message, consumer always ready.
    out_ready = 1'b1;
    i0 = iss_cnt; h0 = hdr_cnt;
    run_msg(16'h1234, 8'hA0);
    wait_done(300);
    chk("t1_issues", 32'(iss_cnt - i0), 32'(P_LEN + 2));
    chk("t1_consecutive", 32'(last_iss_cyc - first_iss_cyc), 32'(P_LEN + 1));
    chk("t1_first_issue", 32'(first_iss_cyc - start_cyc), 32'd1);
    chk("t1_done_lat", 32'(done_cyc - last_iss_cyc), 32'(P_LAT + 1));
    chk("t1_hdr_pulses", 32'(hdr_cnt - h0), 32'd1);
    chk("t1_msg_hdr", 32'(msg_hdr), 32'h1234);
    wait_drain(100);
    chk("t1_empty", 32'(out_valid), 32'd0);

    // Consumer stalled: issue must stop once the FIFO is fully committed.
    out_ready = 1'b0;
    i0 = iss_cnt;
    run_msg(16'h1235, 8'h40);
    tick(60);
    chk("t2_stall_issues", 32'(iss_cnt - i0), 32'(P_DEPTH + 2));
    chk("t2_rq_low", 32'(ram_rd_rq), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_fifo_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_done(400);
    chk("t2_total_issues", 32'(iss_cnt - i0), 32'(P_LEN + 2));
    wait_drain(100);

    // Toggling, then random, consumer readiness.
    for (int m = 0; m < 2; m++) begin
      d0 = done_cnt; n = 0;
      run_msg(16'h1236 + 16'(m), 8'($urandom_range(0, 255)));
      while ((done_cnt == d0 || exp_q.size() != 0) && n < 800) begin
        out_ready = (m == 0) ? ~out_ready : 1'($urandom_range(0, 1));
        tick(1);
        n++;
      end
      chk("t3_finished", 32'(done_cnt != d0 && exp_q.size() == 0), 32'd1);
      chk("t3_done_lat", 32'(done_cyc - last_iss_cyc), 32'(P_LAT + 1));
    end
    out_ready = 1'b1;
    tick(2);

    // start held high throughout a message is ignored.
    i0 = iss_cnt; h0 = hdr_cnt; d0 = done_cnt; n = 0;
    run_msg(16'h1238, 8'h11);
    while (n < 300) begin
      @(negedge clk);
      if (done) begin
        start = 1'b0;
        break;
      end
      chk("t4_busy_hold", 32'(busy), 32'd1);
      @(posedge clk);
      #1 start = 1'b1;
      n++;
    end
    start = 1'b0;
    chk("t4_no_timeout", 32'(n < 300), 32'd1);
    tick(6);
    chk("t4_issues", 32'(iss_cnt - i0), 32'(P_LEN + 2));
    chk("t4_hdr_pulses", 32'(hdr_cnt - h0), 32'd1);
    chk("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
    wait_drain(100);

    // Reset with three payload reads in flight.
    run_msg(16'h0AAA, 8'h20);
    n = 0;
    while (exp_addr < 16'd4 && n < 50) begin
      tick(1);
      n++;
    end
    chk("t5_reached_pay", 32'(exp_addr >= 16'd4), 32'd1);
    rst_l = 1'b0;
    #1;
    chk_reset_vals("t5_rst");
    tick(2);
    exp_q.delete();
    v0 = ovalid_cnt;
    rst_l = 1'b1;
    tick(15);
    chk("t5_no_push", 32'(ovalid_cnt - v0), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    i0 = iss_cnt;
    run_msg(16'h0004, 8'h60);
    wait_done(300);
    chk("t5_restart_issues", 32'(iss_cnt - i0), 32'(P_LEN + 2));
    chk("t5_first_issue", 32'(first_iss_cyc - start_cyc), 32'd1);
    wait_drain(100);

    // Header sequence: 4 (post-reset seed), 5, 6 good; 9 breaks; 10 follows 9.
    run_msg(16'h0005, 8'h70); wait_done(300);
    chk("t6_seq_5", 32'(seq_err), 32'd0);
    run_msg(16'h0006, 8'h80); wait_done(300);
    chk("t6_seq_6", 32'(seq_err), 32'd0);
    run_msg(16'h0009, 8'h90); wait_done(300);
    chk("t6_seq_9", 32'(seq_err), 32'(SEQ_EN));
    tick(3);
    chk("t6_seq_sticky", 32'(seq_err), 32'(SEQ_EN));
    run_msg(16'h000A, 8'hB0);
    chk("t6_seq_clear", 32'(seq_err), 32'd0);
    wait_done(300);
    chk("t6_seq_10", 32'(seq_err), 32'd0);
    chk("t6_last_hdr", 32'(msg_hdr), 32'h000A);
    wait_drain(100);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
